// File: rtl/ctrl_seq_engine_if.sv
// Memory-side request/acknowledge bus of the instruction-sequencing controller:
// one instruction read channel and one result write channel.
interface ctrl_seq_engine_if #(
  parameter int ADDR_W  = 8,
  parameter int REG_W   = 5,
  parameter int INSTR_W = 16
);
  logic               RD_REQ;
  logic [ADDR_W-1:0]  RD_ADDR;
  logic               RD_ACK;
  logic [INSTR_W-1:0] RD_DATA;
  logic               WR_REQ;
  logic [ADDR_W-1:0]  WR_ADDR;
  logic [REG_W-1:0]   WR_DATA;
  logic               WR_ACK;

  modport master (
    output RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA,
    input  RD_ACK, RD_DATA, WR_ACK
  );

  modport slave (
    input  RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA,
    output RD_ACK, RD_DATA, WR_ACK
  );
endinterface

// File: rtl/ctrl_seq_engine.sv
// Instruction-sequencing controller: fetches LEN packed instructions from BASE_ADDR,
// executes one ALU op per instruction and writes each result to (address + OFFSET).
module ctrl_seq_engine #(
  parameter int REG_W  = 5,
  parameter int CNT_W  = 3,
  parameter int ADDR_W = 8,
  parameter int OFFSET = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STRT,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W-1:0] LEN,
  ctrl_seq_engine_if.master mem,
  output logic              BUSY,
  output logic              STOP,
  output logic              ABORTED,
  output logic [ADDR_W-1:0] DONE_CNT
);
  localparam int INSTR_W = 3 + 2*REG_W + CNT_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_base, w_base_nxt;
  logic [ADDR_W-1:0]  r_len, w_len_nxt;
  logic [ADDR_W-1:0]  r_idx, w_idx_nxt;
  logic [ADDR_W-1:0]  w_idx_inc;
  logic [INSTR_W-1:0] r_ir;
  logic [REG_W-1:0]   r_result;
  logic               r_abort_pend;
  logic               r_busy, r_stop, r_aborted;
  logic [ADDR_W-1:0]  r_done_cnt;
  logic               r_rd_req, r_wr_req;
  logic [ADDR_W-1:0]  r_rd_addr, r_wr_addr;
  logic               w_start, w_rd_done, w_wr_done, w_abort_eff;

  function automatic logic [REG_W-1:0] alu(input logic [INSTR_W-1:0] ir);
    logic [2:0]       op;
    logic [REG_W-1:0] a;
    logic [REG_W-1:0] b;
    logic [CNT_W-1:0] c;
    op = ir[INSTR_W-1 -: 3];
    a  = ir[INSTR_W-4 -: REG_W];
    b  = ir[CNT_W +: REG_W];
    c  = ir[CNT_W-1:0];
    case (op)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = REG_W'(0) - a;
      3'd3:    alu = a & b;
      3'd4:    alu = a | b;
      3'd5:    alu = ~a;
      3'd6:    alu = (32'(c) >= REG_W) ? REG_W'(0) : (a >> c);
      3'd7:    alu = (32'(c) >= REG_W) ? REG_W'(0) : (a << c);
      default: alu = REG_W'(0);
    endcase
  endfunction

  assign w_start     = (r_state == S_IDLE) && STRT;
  assign w_rd_done   = (r_state == S_FETCH) && mem.RD_ACK;
  assign w_wr_done   = (r_state == S_WRITE) && mem.WR_ACK;
  assign w_idx_inc   = r_idx + ADDR_W'(1);
  // An abort sampled on the final write edge still counts, as the pending flag sets there too.
  assign w_abort_eff = r_abort_pend | (r_busy & ABORT);

  // Next-state and captured-operand logic
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (STRT) begin
          w_base_nxt  = BASE_ADDR;
          w_len_nxt   = LEN;
          w_idx_nxt   = '0;
          w_state_nxt = (LEN == '0) ? S_DONE : S_FETCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (mem.RD_ACK) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_EXEC:  w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (mem.WR_ACK) begin
          w_idx_nxt   = w_idx_inc;
          w_state_nxt = ((w_idx_inc == r_len) || w_abort_eff) ? S_DONE : S_FETCH;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and request registers; requests are decoded from the next state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_ir      <= '0;
      r_result  <= '0;
      r_rd_req  <= 1'b0;
      r_wr_req  <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_base    <= w_base_nxt;
      r_len     <= w_len_nxt;
      r_idx     <= w_idx_nxt;
      r_rd_req  <= (w_state_nxt == S_FETCH);
      r_wr_req  <= (w_state_nxt == S_WRITE);
      r_rd_addr <= w_base_nxt + w_idx_nxt;
      r_wr_addr <= w_base_nxt + w_idx_nxt + ADDR_W'(OFFSET);
      if (w_rd_done) begin
        r_ir <= mem.RD_DATA;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu(r_ir);
      end
    end
  end

  // Status flags, completion counter and pending abort
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_busy       <= 1'b0;
      r_stop       <= 1'b0;
      r_aborted    <= 1'b0;
      r_done_cnt   <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      if (w_start) begin
        r_busy     <= 1'b1;
        r_stop     <= 1'b0;
        r_aborted  <= 1'b0;
        r_done_cnt <= '0;
      end else if (r_state == S_DONE) begin
        r_busy    <= 1'b0;
        r_stop    <= 1'b1;
        r_aborted <= r_abort_pend;
      end
      if (w_wr_done) begin
        r_done_cnt <= r_done_cnt + ADDR_W'(1);
      end
      if (r_state == S_DONE) begin
        r_abort_pend <= 1'b0;
      end else if (r_busy && ABORT) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

  assign mem.RD_REQ  = r_rd_req;
  assign mem.RD_ADDR = r_rd_addr;
  assign mem.WR_REQ  = r_wr_req;
  assign mem.WR_ADDR = r_wr_addr;
  assign mem.WR_DATA = r_result;
  assign BUSY        = r_busy;
  assign STOP        = r_stop;
  assign ABORTED     = r_aborted;
  assign DONE_CNT    = r_done_cnt;
endmodule
